ab_seq_arbiter: RTL
===================

// Module: ab_seq_arbiter
// PURPOSE
//   Round-robin arbiter/sequencer sharing one a->b/c handshake channel among
//   NREQ requesters. Per grant: one-cycle a pulse, then b and c together after a
//   per-request delay (MIN_DLY or MAX_DLY cycles), then an ended_sig pulse.
//   Drives the a/b/c/ended_sig inputs of the "a ##[2:3] b |-> c" assertion
//   checker, which sits downstream on the same clk.
// PARAMETERS
//   NREQ     4  number of requesters (>=2)
//   MIN_DLY  2  a-to-b delay in cycles when dly_sel=0 (>=1)
//   MAX_DLY  3  a-to-b delay in cycles when dly_sel=1 (>=MIN_DLY)
//   CNT_W    8  width of the completed-sequence counter
// PORTS
//   clk        in   1       clock; all state updates on posedge
//   rst_n      in   1       asynchronous, active-low reset
//   req        in   NREQ    request vector; held high until own ended_sig
//   dly_sel    in   NREQ    per-requester delay select: 0=MIN_DLY, 1=MAX_DLY
//   gnt        out  NREQ    one-hot grant; held from the a cycle through ended_sig
//   a          out  1       sequence start pulse, one cycle
//   b          out  1       response pulse, one cycle, a+dly cycles after a
//   c          out  1       consequent; high in exactly the b cycle
//   ended_sig  out  1       one-cycle pulse, cycle after b
//   busy       out  1       high in every non-IDLE state
//   done_cnt   out  CNT_W   completed sequences; saturates at all-ones
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; gnt, a, b, c, ended_sig, busy=0;
//     done_cnt=0; rr_ptr=0; wait counter=0. Mid-sequence reset aborts it; no
//     b/c/ended_sig pulse is emitted after reset is released.
//   All outputs are registered, decoded from state and the latched grant.
//   FSM states: IDLE, ISSUE_A, WAIT, ISSUE_BC, DONE.
//   - IDLE: if |req, pick the first set bit at or above rr_ptr (wrapping);
//     latch its index and dly = dly_sel[idx] ? MAX_DLY : MIN_DLY; go to ISSUE_A.
//     Otherwise stay in IDLE.
//   - ISSUE_A (cycle k): a=1, gnt=onehot(idx), wcnt=1. If dly==1, go to
//     ISSUE_BC; otherwise go to WAIT.
//   - WAIT: a=0; wcnt increments each cycle. Leave for ISSUE_BC so that b lands
//     exactly at cycle k+dly.
//   - ISSUE_BC (cycle k+dly): b=1, c=1; go to DONE.
//   - DONE (cycle k+dly+1): ended_sig=1; done_cnt++ (saturating);
//     rr_ptr=(idx+1) mod NREQ. Arbitrate as in IDLE using the updated pointer.
//     If any req, go to ISSUE_A; otherwise go to IDLE.
//   Latency: grant decision -> a is 1 cycle. a -> b/c is dly cycles.
//     b -> ended_sig is 1 cycle. Back-to-back a pulses are dly+2 cycles apart.
//   req and dly_sel are sampled only on arbitration in IDLE or DONE. Changes
//     mid-sequence are ignored, and the sequence always completes.
//   The granted requester is lowest priority at the next arbitration, even if
//     its req is still high.
//   a never overlaps b, c or ended_sig. At most one sequence is in flight.
//   Wait counter width is $clog2(MAX_DLY+1); no wrap within a sequence.
//   Elaboration error if MIN_DLY<1, MAX_DLY<MIN_DLY or NREQ<2.
// TESTING
//   1. req=4'b0001, dly_sel=0, a at cycle 10 -> b=c=1 at cycle 12,
//      ended_sig at 13, done_cnt=1, gnt=0001 from cycle 10 through 13.
//   2. req=4'b0100, dly_sel[2]=1, a at cycle 20 -> b=c at 23, ended_sig at 24;
//      the checker reports no violation.
//   3. req=4'b1111 held for 8 sequences -> gnt order 0001,0010,0100,1000,0001,...;
//      a pulses spaced 4 cycles apart (dly=2); done_cnt=8.
//   4. req=4'b0010, drop req at cycle a+1 -> b/c/ended_sig still issued on
//      schedule; FSM then returns to IDLE and busy=0.
//   5. rst_n=0 asserted in the WAIT cycle after a -> all outputs 0 immediately;
//      after release, no b pulse; the next grant starts from requester 0.
//   6. CNT_W=2, 5 sequences -> done_cnt reads 1,2,3,3,3 (saturates).

Source files
------------

// File: rtl/ab_seq_arbiter.sv
// ab_seq_arbiter
//   Round-robin arbiter and sequencer that shares one a -> b/c handshake
//   channel among NREQ requesters. Each grant produces:
//     - a one-cycle pulse on a;
//     - b and c together, dly cycles later, where dly is MIN_DLY or MAX_DLY
//       as chosen by dly_sel;
//     - a one-cycle pulse on ended_sig in the following cycle.
//   Only one sequence is in flight at a time. The requester that was just
//   served has the lowest priority at the next arbitration.
// Ports
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   req        per-requester request; held high until that requester's ended_sig
//   dly_sel    per-requester delay select (0: MIN_DLY, 1: MAX_DLY)
//   gnt        one-hot grant, held from the a cycle through the ended_sig cycle
//   a          sequence start pulse
//   b, c       response and consequent, both high only in the b cycle
//   ended_sig  end-of-sequence pulse, one cycle after b
//   busy       high whenever the FSM is not idle
//   done_cnt   count of completed sequences; saturates at all-ones
module ab_seq_arbiter #(
  parameter int NREQ    = 4,
  parameter int MIN_DLY = 2,
  parameter int MAX_DLY = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  dly_sel,
  output logic [NREQ-1:0]  gnt,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             ended_sig,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WCNT_W = (MAX_DLY >= 1) ? $clog2(MAX_DLY + 1) : 1;

  localparam logic [IDX_W:0]    NREQ_L    = (IDX_W + 1)'(NREQ);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NREQ - 1);
  localparam logic [WCNT_W-1:0] MIN_DLY_L = WCNT_W'(MIN_DLY);
  localparam logic [WCNT_W-1:0] MAX_DLY_L = WCNT_W'(MAX_DLY);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  // Reject parameter sets the sequencing cannot honour.
  if (NREQ < 2) begin : g_err_nreq
    $error("ab_seq_arbiter: NREQ must be >= 2");
  end
  if (MIN_DLY < 1) begin : g_err_min_dly
    $error("ab_seq_arbiter: MIN_DLY must be >= 1");
  end
  if (MAX_DLY < MIN_DLY) begin : g_err_max_dly
    $error("ab_seq_arbiter: MAX_DLY must be >= MIN_DLY");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_A  = 3'd1,
    WAIT     = 3'd2,
    ISSUE_BC = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t            state_r;
  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  rr_ptr_r;
  logic [WCNT_W-1:0] dly_r;
  logic [WCNT_W-1:0] wcnt_r;

  logic              arb_hit_s;
  logic [IDX_W-1:0]  arb_idx_s;
  logic [WCNT_W-1:0] arb_dly_s;
  logic [IDX_W:0]    cand_s;
  logic [IDX_W-1:0]  nxt_ptr_s;

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = {NREQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search: first requester at or above rr_ptr_r, wrapping around.
  always_comb begin
    arb_hit_s = 1'b0;
    arb_idx_s = {IDX_W{1'b0}};
    cand_s    = {(IDX_W + 1){1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      cand_s = {1'b0, rr_ptr_r} + (IDX_W + 1)'(i);
      if (cand_s >= NREQ_L) begin
        cand_s = cand_s - NREQ_L;
      end else begin
        cand_s = cand_s;
      end
      if (!arb_hit_s && req[cand_s[IDX_W-1:0]]) begin
        arb_hit_s = 1'b1;
        arb_idx_s = cand_s[IDX_W-1:0];
      end else begin
        arb_hit_s = arb_hit_s;
        arb_idx_s = arb_idx_s;
      end
    end
    if (dly_sel[arb_idx_s]) begin
      arb_dly_s = MAX_DLY_L;
    end else begin
      arb_dly_s = MIN_DLY_L;
    end
  end

  // Pointer past the requester being served, so that it ranks last next time.
  always_comb begin
    if (idx_r == LAST_IDX) begin
      nxt_ptr_s = {IDX_W{1'b0}};
    end else begin
      nxt_ptr_s = idx_r + IDX_W'(1);
    end
  end

  // Sequencer FSM. The outputs are registered alongside the next state, so
  // each output is already valid in the cycle its state becomes current.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      idx_r     <= {IDX_W{1'b0}};
      rr_ptr_r  <= {IDX_W{1'b0}};
      dly_r     <= {WCNT_W{1'b0}};
      wcnt_r    <= {WCNT_W{1'b0}};
      gnt       <= {NREQ{1'b0}};
      a         <= 1'b0;
      b         <= 1'b0;
      c         <= 1'b0;
      ended_sig <= 1'b0;
      busy      <= 1'b0;
      done_cnt  <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE: begin
          b         <= 1'b0;
          c         <= 1'b0;
          ended_sig <= 1'b0;
          if (arb_hit_s) begin
            state_r <= ISSUE_A;
            idx_r   <= arb_idx_s;
            dly_r   <= arb_dly_s;
            wcnt_r  <= WCNT_W'(1);
            gnt     <= onehot(arb_idx_s);
            a       <= 1'b1;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            wcnt_r  <= {WCNT_W{1'b0}};
            gnt     <= {NREQ{1'b0}};
            a       <= 1'b0;
            busy    <= 1'b0;
          end
        end
        ISSUE_A, WAIT: begin
          // wcnt_r counts cycles since a; b must land exactly dly cycles after a.
          a <= 1'b0;
          if (wcnt_r == dly_r) begin
            state_r <= ISSUE_BC;
            b       <= 1'b1;
            c       <= 1'b1;
          end else begin
            state_r <= WAIT;
            wcnt_r  <= wcnt_r + WCNT_W'(1);
          end
        end
        ISSUE_BC: begin
          state_r   <= DONE;
          b         <= 1'b0;
          c         <= 1'b0;
          ended_sig <= 1'b1;
          wcnt_r    <= {WCNT_W{1'b0}};
          rr_ptr_r  <= nxt_ptr_s;
          if (done_cnt != CNT_MAX) begin
            done_cnt <= done_cnt + CNT_W'(1);
          end else begin
            done_cnt <= done_cnt;
          end
        end
        default: begin
          state_r   <= IDLE;
          wcnt_r    <= {WCNT_W{1'b0}};
          gnt       <= {NREQ{1'b0}};
          a         <= 1'b0;
          b         <= 1'b0;
          c         <= 1'b0;
          ended_sig <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
